// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier.
// Operand A is taken from data_in with start and operand B with a later
// data_valid. The core always multiplies unsigned magnitudes. In signed
// mode the sign of the product is applied when the result is written.
//
// state  | meaning
// IDLE   | waiting for start, result is held
// LOAD_B | A captured, waiting for data_valid to supply B
// CALC   | WIDTH shift-add iterations
// DONE   | done pulse, result valid, start is accepted again
module seq_mult_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 data_valid,
    input  logic                 signed_mode,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_B = 2'd1,
        S_CALC   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [CNT_W-1:0]     cnt;
    logic                 mode;
    logic                 a_sign;
    logic                 neg;
    logic                 accept_a;
    logic                 accept_b;
    logic                 last_iter;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   prod_shift;
    logic [2*WIDTH-1:0]   prod_final;

    // Convert to an unsigned magnitude. -2^(WIDTH-1) maps to 2^(WIDTH-1) exactly.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and control outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept_a  = 1'b0;
        accept_b  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept_a  = 1'b1;
                    state_nxt = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                busy = 1'b1;
                if (data_valid) begin
                    accept_b  = 1'b1;
                    state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (last_iter) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
                if (start) begin
                    accept_a  = 1'b1;
                    state_nxt = S_LOAD_B;
                end
                else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // One shift-add step. The WIDTH+1-bit sum keeps the carry out of the accumulator.
    always_comb begin
        last_iter  = (cnt == CNT_W'(WIDTH - 1));
        sum        = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_shift = {sum, prod[WIDTH-1:1]};
        prod_final = neg ? (2*WIDTH)'(-prod_shift) : prod_shift;
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            prod   <= '0;
            cnt    <= '0;
            mode   <= 1'b0;
            a_sign <= 1'b0;
            neg    <= 1'b0;
            result <= '0;
        end
        else begin
            if (accept_a) begin
                mcand  <= magnitude(data_in, signed_mode);
                a_sign <= signed_mode & data_in[WIDTH-1];
                mode   <= signed_mode;
            end
            if (accept_b) begin
                prod <= {{WIDTH{1'b0}}, magnitude(data_in, mode)};
                neg  <= a_sign ^ (mode & data_in[WIDTH-1]);
                cnt  <= '0;
            end
            else if (state == S_CALC) begin
                prod <= prod_shift;
                cnt  <= cnt + CNT_W'(1);
                // The result is written on the last iteration edge so that it is valid during done.
                if (last_iter) result <= prod_final;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param at WIDTH=8. Expected products are queued
// when B is driven and are checked against the DUT when done pulses.
module tb_seq_mult_param;

    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] res;
        int             cap;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [W-1:0]    data_in = '0;
    logic            data_valid = 1'b0;
    logic            signed_mode = 1'b0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  result;

    exp_t sb[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    seq_mult_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in),
        .data_valid(data_valid), .signed_mode(signed_mode),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference products computed with ordinary integer arithmetic.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int av;
        int bv;
        av = s ? int'($signed(a)) : int'(a);
        bv = s ? int'($signed(b)) : int'(b);
        return (2*W)'(av * bv);
    endfunction

    // Scoreboard: each done pulse pops one expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("done_without_op", 32'(sb.size()), 32'd1);
            end
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("latency", 32'(cyc - e.cap), 32'(W));
                chk("busy_in_done", 32'(busy), 32'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [W-1:0] a, input logic s);
        start = 1'b1;
        data_in = a;
        signed_mode = s;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Drives B; exp is the product the current operation must produce.
    task automatic do_b(input logic [W-1:0] b, input logic [2*W-1:0] exp);
        exp_t e;
        data_valid = 1'b1;
        data_in = b;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        e.res = exp;
        e.cap = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int d0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        idle(2);
        rst = 1'b0;
        idle(1);

        // Unsigned 3x4 with a gap before B.
        do_start(8'd3, 1'b0);
        chk("busy_loadb", 32'(busy), 32'd1);
        idle(1);
        do_b(8'd4, 16'd12);
        drain();
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("result_held", 32'(result), 32'd12);

        // Unsigned boundary, then zero operand.
        do_start(8'd255, 1'b0);
        do_b(8'd255, 16'hFE01);
        drain();
        do_start(8'd0, 1'b0);
        do_b(8'd200, 16'd0);
        drain();

        // Signed cases; the mode change before the last B must not matter.
        do_start(8'hFD, 1'b1);
        do_b(8'd4, ref_mul(8'hFD, 8'd4, 1'b1));
        drain();
        do_start(8'h80, 1'b1);
        do_b(8'h80, 16'h4000);
        drain();
        do_start(8'h80, 1'b1);
        signed_mode = 1'b0;
        do_b(8'h7F, 16'hC080);
        drain();

        // Ignored start/data_valid during CALC; start with data_valid in IDLE.
        start = 1'b1;
        data_valid = 1'b1;
        data_in = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        data_valid = 1'b0;
        idle(1);
        chk("idle_dv_ignored", 32'(busy), 32'd1);
        d0 = done_cnt;
        do_b(8'd6, 16'd30);
        start = 1'b1;
        data_in = 8'd99;
        @(posedge clk);
        #1;
        start = 1'b0;
        data_valid = 1'b1;
        data_in = 8'd77;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        drain();
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        idle(3);
        chk("no_extra_done", 32'(done_cnt - d0), 32'd1);

        // Reset three cycles into CALC.
        do_start(8'd11, 1'b0);
        do_b(8'd13, 16'd143);
        idle(2);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        sb.delete();
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(12);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        do_start(8'd7, 1'b0);
        do_b(8'd9, 16'd63);
        drain();

        // Back-to-back: new start accepted in the DONE cycle.
        do_start(8'd5, 1'b0);
        do_b(8'd6, 16'd30);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("b2b_done_seen", 32'(seen), 32'd1);
        end
        start = 1'b1;
        data_in = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_loadb_busy", 32'(busy), 32'd1);
        chk("b2b_result_held", 32'(result), 32'd30);
        do_b(8'd10, 16'd20);
        drain();
        chk("b2b_busy_end", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
